// File: rtl/reg_bus_sequencer.sv
// Memory-bus stage: queues register-manager requests, runs them one at a time
// against the mem_rd/mem_wr/mem_ack handshake and broadcasts each completion.
//   state    | meaning
//   S_IDLE   | waiting for a queued request; pops the FIFO head when one exists
//   S_ACCESS | strobe held on the memory bus until ack or timeout
//   S_DONE   | one-cycle completion broadcast
module reg_bus_sequencer #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 15
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_read_q,
    input  logic              i_write_q,
    input  logic [ADDR_W-1:0] i_req_addr,
    input  logic [DATA_W-1:0] i_req_data,
    output logic              o_req_full,
    output logic              o_req_err,
    output logic              o_is_bus_busy,
    output logic              o_read_dn,
    output logic              o_write_dn,
    output logic [ADDR_W-1:0] o_addr,
    output logic [DATA_W-1:0] o_data,
    output logic              o_bus_err,
    output logic              o_mem_rd,
    output logic              o_mem_wr,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic [DATA_W-1:0] o_mem_wdata,
    input  logic [DATA_W-1:0] i_mem_rdata,
    input  logic              i_mem_ack
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam int EW = 1 + ADDR_W + DATA_W;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

    typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_DONE} state_t;

    state_t            r_state;
    state_t            w_next;
    logic [EW-1:0]     r_mem [DEPTH];
    logic [PW-1:0]     r_wr_ptr;
    logic [PW-1:0]     r_rd_ptr;
    logic [CW-1:0]     r_count;
    logic [TW-1:0]     r_tmo;
    logic              r_acc_wr;
    logic [ADDR_W-1:0] r_acc_addr;
    logic [DATA_W-1:0] r_acc_wdata;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_data;
    logic              r_bus_err;
    logic              r_req_full;
    logic              r_req_err;

    logic              w_any;
    logic              w_push;
    logic              w_pop;
    logic              w_tmo_hit;
    logic              w_finish;
    logic [CW-1:0]     w_count_nxt;

    // Fullness uses the count before the edge, so a same-edge pop never frees a slot.
    assign w_any       = i_read_q | i_write_q;
    assign w_push      = w_any && (r_count != FULL_CNT);
    assign w_pop       = (r_state == S_IDLE) && (r_count != '0);
    assign w_tmo_hit   = (r_tmo == TMO_LAST);
    assign w_finish    = (r_state == S_ACCESS) && (w_next == S_DONE);
    assign w_count_nxt = r_count + CW'(w_push) - CW'(w_pop);

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   if (w_pop) w_next = S_ACCESS;
            S_ACCESS: if (i_mem_ack || w_tmo_hit) w_next = S_DONE;
            S_DONE:   w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    always_ff @(posedge i_clk) begin
        if (w_push && !i_rst) r_mem[r_wr_ptr] <= {i_write_q, i_req_addr, i_req_data};
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_tmo       <= '0;
            r_acc_wr    <= 1'b0;
            r_acc_addr  <= '0;
            r_acc_wdata <= '0;
            r_addr      <= '0;
            r_data      <= '0;
            r_bus_err   <= 1'b0;
            r_req_full  <= 1'b0;
            r_req_err   <= 1'b0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
            if (w_pop) begin
                {r_acc_wr, r_acc_addr, r_acc_wdata} <= r_mem[r_rd_ptr];
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end
            r_count    <= w_count_nxt;
            r_req_full <= (w_count_nxt == FULL_CNT);
            r_req_err  <= (i_read_q & i_write_q) | (w_any & (r_count == FULL_CNT));
            if ((r_state == S_ACCESS) && (w_next == S_ACCESS)) r_tmo <= r_tmo + TW'(1);
            else                                               r_tmo <= '0;
            if (w_finish) begin
                r_addr    <= r_acc_addr;
                r_data    <= r_acc_wr ? r_acc_wdata : (i_mem_ack ? i_mem_rdata : '0);
                r_bus_err <= ~i_mem_ack;
            end
        end
    end

    assign o_req_full    = r_req_full;
    assign o_req_err     = r_req_err;
    assign o_is_bus_busy = (r_state == S_DONE);
    assign o_read_dn     = (r_state == S_DONE) && !r_acc_wr;
    assign o_write_dn    = (r_state == S_DONE) && r_acc_wr;
    assign o_bus_err     = (r_state == S_DONE) && r_bus_err;
    assign o_addr        = r_addr;
    assign o_data        = r_data;
    assign o_mem_rd      = (r_state == S_ACCESS) && !r_acc_wr;
    assign o_mem_wr      = (r_state == S_ACCESS) && r_acc_wr;
    assign o_mem_addr    = r_acc_addr;
    assign o_mem_wdata   = r_acc_wdata;

endmodule

// File: tb/tb_reg_bus_sequencer.sv
// Directed and randomized bench for reg_bus_sequencer against a transaction-level
// model: a request queue, an in-flight access with a wait budget, and a broadcast slot.
module tb_reg_bus_sequencer;

    localparam int DEPTH   = 4;
    localparam int TIMEOUT = 15;

    logic        clk = 1'b0;
    logic        rst, read_q, write_q, mem_ack;
    logic [31:0] req_addr, req_data, mem_rdata;
    logic        req_full, req_err, is_bus_busy, read_dn, write_dn, bus_err, mem_rd, mem_wr;
    logic [31:0] addr, data, mem_addr, mem_wdata;

    reg_bus_sequencer #(.ADDR_W(32), .DATA_W(32), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
        .i_clk(clk), .i_rst(rst), .i_read_q(read_q), .i_write_q(write_q),
        .i_req_addr(req_addr), .i_req_data(req_data),
        .o_req_full(req_full), .o_req_err(req_err), .o_is_bus_busy(is_bus_busy),
        .o_read_dn(read_dn), .o_write_dn(write_dn), .o_addr(addr), .o_data(data),
        .o_bus_err(bus_err), .o_mem_rd(mem_rd), .o_mem_wr(mem_wr),
        .o_mem_addr(mem_addr), .o_mem_wdata(mem_wdata),
        .i_mem_rdata(mem_rdata), .i_mem_ack(mem_ack)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          w;
        logic [31:0] a;
        logic [31:0] d;
    } req_t;

    // Model: pending requests, the one in flight, and what the broadcast should show.
    req_t        mq[$];
    req_t        cur;
    int          phase;      // 0 waiting, 1 on the memory bus, 2 broadcasting
    int          acc_cycles; // memory-bus cycles already spent on cur
    int          wait_goal;  // cycle on which the responder acks cur (0 = never)
    logic [31:0] e_addr, e_data;
    bit          e_berr, e_err;

    int          ack_w = 2;
    bit          rnd_ack = 0;
    bit          fix_rdata = 0;
    int          n_vec = 0;
    int          n_miss = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_miss++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input bit r, input bit rq, input bit wq, input logic [31:0] a, input logic [31:0] d);
        bit          ack;
        logic [31:0] rdat;
        int          sz;
        rdat = fix_rdata ? 32'hDEADBEEF : $urandom;
        if (phase == 1) ack = (wait_goal != 0) && (acc_cycles + 1 == wait_goal);
        else            ack = 1'($urandom_range(0, 1));
        rst = r; read_q = rq; write_q = wq; req_addr = a; req_data = d;
        mem_ack = ack; mem_rdata = rdat;
        @(posedge clk);
        if (r) begin
            mq.delete();
            phase = 0; acc_cycles = 0;
            e_addr = 0; e_data = 0; e_berr = 0; e_err = 0;
        end else begin
            sz = mq.size();
            e_err = (rq && wq) || ((rq || wq) && sz == DEPTH);
            case (phase)
                0: if (sz > 0) begin
                    cur = mq.pop_front();
                    phase = 1; acc_cycles = 0;
                    wait_goal = rnd_ack ? (($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 4))) : ack_w;
                end
                1: begin
                    if (ack || acc_cycles + 1 == TIMEOUT) begin
                        phase  = 2;
                        e_addr = cur.a;
                        e_berr = !ack;
                        e_data = cur.w ? cur.d : (ack ? rdat : 32'h0);
                    end else acc_cycles++;
                end
                default: phase = 0;
            endcase
            if ((rq || wq) && sz < DEPTH) mq.push_back('{w: wq, a: a, d: d});
        end
        @(negedge clk);
        chk("req_full", req_full, 32'(mq.size() == DEPTH));
        chk("req_err", req_err, 32'(e_err));
        chk("is_bus_busy", is_bus_busy, 32'(phase == 2));
        chk("read_dn", read_dn, 32'(phase == 2 && !cur.w));
        chk("write_dn", write_dn, 32'(phase == 2 && cur.w));
        chk("bus_err", bus_err, 32'(phase == 2 && e_berr));
        chk("addr", addr, e_addr);
        chk("data", data, e_data);
        chk("mem_rd", mem_rd, 32'(phase == 1 && !cur.w));
        chk("mem_wr", mem_wr, 32'(phase == 1 && cur.w));
        if (phase == 1) begin
            chk("mem_addr", mem_addr, cur.a);
            if (cur.w) chk("mem_wdata", mem_wdata, cur.d);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(0, 0, 0, 32'h0, 32'h0);
    endtask

    initial begin
        rst = 1; read_q = 0; write_q = 0; req_addr = 0; req_data = 0;
        mem_ack = 0; mem_rdata = 0;
        phase = 0; acc_cycles = 0; wait_goal = 0;
        cur = '{w: 0, a: 0, d: 0};
        e_addr = 0; e_data = 0; e_berr = 0; e_err = 0;
        @(negedge clk);
        cyc(1, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0);

        // single read with a fixed response word
        fix_rdata = 1; ack_w = 2;
        cyc(0, 1, 0, 32'h10, 32'h0);
        idle(6);
        fix_rdata = 0;

        // burst of writes overrunning the FIFO, slow memory
        ack_w = 4;
        for (int i = 0; i < 6; i++) cyc(0, 0, 1, 32'h100 + 32'(i * 4), 32'hA000 + 32'(i));
        idle(40);

        // read and write together: only the write goes in
        ack_w = 1;
        cyc(0, 1, 1, 32'h20, 32'h55);
        idle(5);

        // timed-out read followed by a normal read
        ack_w = 0;
        cyc(0, 1, 0, 32'h30, 32'h0);
        cyc(0, 1, 0, 32'h34, 32'h0);
        ack_w = 2;
        idle(25);

        // reset in the middle of an access with two entries queued
        ack_w = 0;
        cyc(0, 1, 0, 32'h40, 32'h0);
        cyc(0, 0, 1, 32'h44, 32'h1);
        cyc(0, 1, 0, 32'h48, 32'h0);
        idle(2);
        cyc(1, 0, 0, 32'h0, 32'h0);
        ack_w = 1;
        cyc(0, 1, 0, 32'h50, 32'h0);
        idle(5);

        // steady stream so pushes and pops coincide and pointers wrap
        ack_w = 1;
        for (int i = 0; i < 8; i++) begin
            cyc(0, i[0], !i[0], 32'h200 + 32'(i * 4), 32'hB000 + 32'(i));
            cyc(0, 0, 0, 0, 0);
        end
        idle(20);

        // randomized traffic with random memory wait, timeouts and rare resets
        rnd_ack = 1;
        for (int i = 0; i < 600; i++) begin
            int sel;
            sel = int'($urandom_range(0, 9));
            cyc($urandom_range(0, 199) == 0, sel <= 2 || sel == 6, (sel >= 3 && sel <= 5) || sel == 6,
                $urandom, $urandom);
        end
        idle(30 * DEPTH);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
